uart_byte_rx: RTL and testbench

//  Asynchronous serial (8N1, LSB first) byte receiver. Feeds the host command

---
 rtl/uart_byte_rx.sv | 142 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 LSB-first serial byte receiver: synchronises the rx pin, samples each bit
// at mid-bit and emits one-clock byte strobes or framing-error pulses.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_strb,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [1:0]       sync_r;
  logic             rx_s;
  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shift_r, shift_s;
  logic [7:0]       rx_data_r, rx_data_s;
  logic             rx_strb_r, rx_strb_s;
  logic             frame_err_r, frame_err_s;
  logic             busy_r;

  assign rx_s      = sync_r[1];
  assign rx_data   = rx_data_r;
  assign rx_strb   = rx_strb_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

  // Next-state and datapath decisions, all taken from the synchronised line.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    shift_s     = shift_r;
    rx_data_s   = rx_data_r;
    rx_strb_s   = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_s == 1'b0) begin
          state_s = ST_START;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_r == CNT_HALF_M1) begin
          cnt_s = '0;
          if (rx_s == 1'b1) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DATA;
            idx_s   = 3'd0;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s          = '0;
          shift_s[idx_r] = rx_s;
          if (idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = '0;
          if (rx_s == 1'b1) begin
            rx_data_s = shift_r;
            rx_strb_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_s     = ST_BREAK;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before any new start bit counts.
        if (rx_s == 1'b1) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Synchroniser, state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r      <= 2'b11;
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      rx_strb_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sync_r      <= {sync_r[0], rx};
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      rx_data_r   <= rx_data_s;
      rx_strb_r   <= rx_strb_s;
      frame_err_r <= frame_err_s;
      busy_r      <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: bit-accurate pin driver plus a queue of
// expected bytes and timing rules derived from the serial framing.
module tb_uart_byte_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_strb;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic       got_busy_q[$];
  int         ferr_cnt = 0;
  logic       strb_prev = 1'b0;
  logic       ferr_prev = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_strb   (rx_strb),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect strobes, count frame errors, check pulse shape.
  always @(negedge clk) begin
    if (rx_strb) begin
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
      got_busy_q.push_back(busy);
    end
    if (frame_err) ferr_cnt++;
    if (rx_strb || frame_err) begin
      n_checks++;
      if ((rx_strb && frame_err) || (rx_strb && strb_prev) || (frame_err && ferr_prev)) begin
        n_fail++;
        $display("FAIL pulse_shape: strb=%b ferr=%b prev_strb=%b prev_ferr=%b, required single exclusive pulses",
                 rx_strb, frame_err, strb_prev, ferr_prev);
      end
    end
    strb_prev = rx_strb;
    ferr_prev = frame_err;
  end

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(1'b1);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc_q.delete();
    got_busy_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic drain();
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_data, rx_strb, frame_err, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h strb=%b ferr=%b busy=%b, required all 0",
               rx_data, rx_strb, frame_err, busy);
    end
    reset = 1'b0;
    last_good = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int c0;
    int exp_cyc;
    clear_mon();
    c0 = cyc;
    // Two synchroniser clocks, then half a bit plus nine bits, plus one registered cycle.
    exp_cyc = c0 + 2 + HALF + 9 * CPB + 1;
    send_byte(8'hA5);
    drain();
    n_checks++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d strobes, required 1", got_q.size());
    end
    if (got_q.size() >= 1) begin
      n_checks++;
      if (got_q[0] !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_data: got %h, required a5", got_q[0]);
      end
      n_checks++;
      if (got_cyc_q[0] !== exp_cyc) begin
        n_fail++;
        $display("FAIL single_latency: strobe at cycle %0d, required %0d", got_cyc_q[0], exp_cyc);
      end
      n_checks++;
      if (got_busy_q[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_busy: busy=%b at strobe, required 0", got_busy_q[0]);
      end
      last_good = 8'hA5;
    end
    n_checks++;
    if (ferr_cnt !== 0) begin
      n_fail++;
      $display("FAIL single_ferr: got %0d frame errors, required 0", ferr_cnt);
    end
  endtask

  task automatic test_back_to_back(input string name, input logic [7:0] bytes[$]);
    clear_mon();
    foreach (bytes[i]) send_byte(bytes[i]);
    drain();
    n_checks++;
    if (got_q.size() !== bytes.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d strobes, required %0d", name, got_q.size(), bytes.size());
    end
    for (int i = 0; i < bytes.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== bytes[i]) begin
        n_fail++;
        $display("FAIL %s_data[%0d]: got %h, required %h", name, i, got_q[i], bytes[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (got_cyc_q[i] - got_cyc_q[i-1] !== 10 * CPB) begin
          n_fail++;
          $display("FAIL %s_spacing[%0d]: got %0d clocks, required %0d",
                   name, i, got_cyc_q[i] - got_cyc_q[i-1], 10 * CPB);
        end
      end
    end
    if (bytes.size() > 0) last_good = bytes[bytes.size() - 1];
    n_checks++;
    if (ferr_cnt !== 0) begin
      n_fail++;
      $display("FAIL %s_ferr: got %0d frame errors, required 0", name, ferr_cnt);
    end
  endtask

  task automatic test_one_byte(input string name, input logic [7:0] b);
    clear_mon();
    send_byte(b);
    drain();
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== b) begin
      n_fail++;
      $display("FAIL %s: got %0d strobes first=%h, required 1 strobe with %h",
               name, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
    end
    last_good = b;
  endtask

  task automatic test_glitch();
    int busy_cycles;
    clear_mon();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    busy_cycles = 0;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles < 1 || busy_cycles > HALF + 1) begin
      n_fail++;
      $display("FAIL glitch_busy: busy for %0d clocks, required 1..%0d", busy_cycles, HALF + 1);
    end
    n_checks++;
    if (got_q.size() !== 0 || ferr_cnt !== 0) begin
      n_fail++;
      $display("FAIL glitch_outputs: got %0d strobes %0d ferr, required 0 and 0", got_q.size(), ferr_cnt);
    end
    test_one_byte("glitch_next", 8'h5A);
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    b = 8'h3C;
    clear_mon();
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    repeat (3) bit_out(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_busy_held: busy=%b while line low, required 1", busy);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_busy_release: busy=%b after line high, required 0", busy);
    end
    n_checks++;
    if (ferr_cnt !== 1 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ferr_pulses: got %0d ferr %0d strobes, required 1 and 0", ferr_cnt, got_q.size());
    end
    n_checks++;
    if (rx_data !== last_good) begin
      n_fail++;
      $display("FAIL ferr_data_kept: got %h, required %h", rx_data, last_good);
    end
    test_one_byte("ferr_next", 8'hC3);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h77;
    clear_mon();
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    rx = b[4];
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rx_data, rx_strb, frame_err, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got data=%h strb=%b ferr=%b busy=%b, required all 0",
               rx_data, rx_strb, frame_err, busy);
    end
    reset = 1'b0;
    last_good = 8'h00;
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 0 || ferr_cnt !== 0) begin
      n_fail++;
      $display("FAIL midreset_silent: got %0d strobes %0d ferr, required 0 and 0", got_q.size(), ferr_cnt);
    end
    test_one_byte("midreset_next", 8'h81);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int gap;
    clear_mon();
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      exp_q.push_back(b);
      send_byte(b);
      repeat (gap * CPB) @(negedge clk);
    end
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (ferr_cnt !== 0) begin
      n_fail++;
      $display("FAIL random_ferr: got %0d frame errors, required 0", ferr_cnt);
    end
  endtask

  initial begin
    logic [7:0] seq_a[$];
    logic [7:0] seq_b[$];
    seq_a = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
    seq_b = '{8'h00, 8'hFF};
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back("b2b", seq_a);
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back("edges", seq_b);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
